sc_speed_timer: RTL and testbench
=================================

SC_SPEED_TIMER -- requirements
Module: sc_speed_timer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 24: counter/period width.
REQ-002 SHALL have parameter PERIOD_DEFAULT, default 24'h65B9AB: period after reset.
REQ-003 SHALL have parameter PERIOD_MIN, default 24'd2: lower clamp for any period.
REQ-004 SHALL have port SC_SPEED_TIMER_CLOCK_50  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port SC_SPEED_TIMER_RESET_InHigh  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port SC_SPEED_TIMER_start_InLow  in  1: low level starts timer from IDLE.
REQ-007 SHALL have port SC_SPEED_TIMER_pause_InLow  in  1: low level holds count while running.
REQ-008 SHALL have port SC_SPEED_TIMER_load_InLow  in  1: one-cycle low strobe loads a new period.
REQ-009 SHALL have port SC_SPEED_TIMER_period_InBUS  in  DATAWIDTH: period value, sampled on load.
REQ-010 SHALL have port SC_SPEED_TIMER_data_OutBUS  out  DATAWIDTH: current count, registered.
REQ-011 SHALL have port SC_SPEED_TIMER_T0_OutLow  out  1: registered tick, low for one cycle per period.
REQ-012 SHALL have port SC_SPEED_TIMER_running_OutHigh  out  1: high while FSM is in RUN.
REQ-013 SHALL have port SC_SPEED_TIMER_level_OutBUS  out  4: current speed level.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-015 SHALL go IDLE->RUN when start_InLow=0; IDLE ignores pause_InLow.
REQ-016 SHALL go RUN->PAUSE when pause_InLow=0, and PAUSE->RUN when pause_InLow=1.
REQ-017 SHALL, in RUN, increment count by 1 each cycle; in IDLE/PAUSE, hold count.
REQ-018 SHALL, in RUN with count == period-1, load count 0 and drive T0_OutLow=0 on that same edge; T0_OutLow=1 on every other cycle.
REQ-019 SHALL yield tick spacing of exactly period cycles in uninterrupted RUN; PAUSE cycles extend spacing by their count.
REQ-020 SHALL, on load_InLow=0, register period = max(period_InBUS, PERIOD_MIN), clear count to 0, keep FSM state.
REQ-021 SHALL give load priority over wrap in the same cycle: count 0, no tick.
REQ-022 SHALL treat a new period smaller than current count correctly only via the load-clears-count rule (no overrun possible).
REQ-023 SHALL never let count exceed period-1; arithmetic unsigned, DATAWIDTH bits.

Reset
REQ-024 SHALL, with RESET_InHigh=1 at an edge, set state IDLE, count 0, period PERIOD_DEFAULT, T0_OutLow 1, running_OutHigh 0, level 0, tick counter 0.
REQ-025 SHALL override start, pause, load and wrap with reset, including mid-period.

Configuration
REQ-026 SHALL, with SC_SPEED_TIMER_LEVELUP_EN defined, count ticks and every 8th tick reduce period by PERIOD_MIN*4 saturating at PERIOD_MIN, and increment level saturating at 15; load resets level and tick counter to 0.
REQ-027 SHALL, without SC_SPEED_TIMER_LEVELUP_EN, keep period constant except on load and tie level_OutBUS to 0.
REQ-028 SHALL apply a level-up period change on the wrap edge itself, effective for the following period.

Structure
REQ-029 SHALL place DATAWIDTH default, PERIOD_DEFAULT, PERIOD_MIN, level width and FSM state encoding in package sc_speed_pkg.
REQ-030 SHALL isolate level-up logic in sub-module sc_speed_level, instantiated only under SC_SPEED_TIMER_LEVELUP_EN.

Verification
REQ-031 SHALL cover: reset, start low 1 cycle -> running=1 next cycle, first T0 low exactly 0x65B9AB cycles after counting begins.
REQ-032 SHALL cover: load 5 in RUN -> count 0,1,2,3,4,0; T0 low once every 5 cycles.
REQ-033 SHALL cover: load 0 -> period clamps to 2; T0 low every 2nd cycle.
REQ-034 SHALL cover: period 5, pause low 3 cycles at count 2 -> count holds 2, next tick 8 cycles after previous.
REQ-035 SHALL cover: load asserted on wrap cycle with period_InBUS 7 -> no tick, count 0, next tick after 7 cycles.
REQ-036 SHALL cover (LEVELUP_EN): load 20 -> after 8 ticks level 1, period 12; after 16 ticks level 2, period 4; then period 2, level increments to 15 max; reset mid-period -> all outputs to reset values.

Source files
------------

// File: rtl/sc_speed_pkg.sv
// sc_speed_pkg -- shared constants and state encoding for the speed timer.
//   DATAWIDTH_DEF      : default counter/period width
//   PERIOD_DEFAULT_DEF : period loaded at reset
//   PERIOD_MIN_DEF     : lower clamp for any period
//   LEVEL_W            : width of the speed level output
//   TICKS_PER_LEVEL    : ticks between level-ups (level-up build only)
//   speedState_e       : FSM state encoding
package sc_speed_pkg;

    localparam int          DATAWIDTH_DEF      = 24;
    localparam logic [23:0] PERIOD_DEFAULT_DEF = 24'h65B9AB;
    localparam logic [23:0] PERIOD_MIN_DEF     = 24'd2;
    localparam int          LEVEL_W            = 4;
    localparam int          TICKS_PER_LEVEL    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } speedState_e;

endpackage

// File: rtl/sc_speed_level.sv
// sc_speed_level -- counts period ticks and raises the speed level every
// TICKS_PER_LEVEL ticks. Only instantiated when SC_SPEED_TIMER_LEVELUP_EN is set.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   tick    : one-cycle pulse on every period wrap
//   load    : one-cycle pulse (active-high) when a new period is loaded
//   levelUp : combinational, high on the wrap that completes a group of ticks
//   level   : current speed level, saturating at its maximum
module sc_speed_level
    import sc_speed_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    output logic               levelUp,
    output logic [LEVEL_W-1:0] level
);

    localparam int TCNT_W = $clog2(TICKS_PER_LEVEL);

    logic [TCNT_W-1:0] tickCount;

    assign levelUp = tick && (tickCount == TCNT_W'(TICKS_PER_LEVEL - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            tickCount <= '0;
            level     <= '0;
        end else if (tick) begin
            // The tick counter wraps naturally; level holds at all-ones.
            tickCount <= tickCount + 1'b1;
            if (levelUp && (level != {LEVEL_W{1'b1}})) begin
                level <= level + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_speed_timer.sv
// sc_speed_timer -- programmable period timer with IDLE/RUN/PAUSE control.
// Optional feature: define SC_SPEED_TIMER_LEVELUP_EN to shorten the period and
// raise the speed level every few ticks (see sc_speed_level).
//   SC_SPEED_TIMER_CLOCK_50        : clock, rising edge
//   SC_SPEED_TIMER_RESET_InHigh    : synchronous active-high reset
//   SC_SPEED_TIMER_start_InLow     : low starts the timer from IDLE
//   SC_SPEED_TIMER_pause_InLow     : low holds the count while running
//   SC_SPEED_TIMER_load_InLow      : one-cycle low strobe loads a new period
//   SC_SPEED_TIMER_period_InBUS    : period value sampled on load
//   SC_SPEED_TIMER_data_OutBUS     : current count (registered)
//   SC_SPEED_TIMER_T0_OutLow       : registered tick, low one cycle per period
//   SC_SPEED_TIMER_running_OutHigh : high while in RUN
//   SC_SPEED_TIMER_level_OutBUS    : current speed level (0 without level-up)
module sc_speed_timer
    import sc_speed_pkg::*;
#(
    parameter int                   DATAWIDTH      = DATAWIDTH_DEF,
    parameter logic [DATAWIDTH-1:0] PERIOD_DEFAULT = DATAWIDTH'(PERIOD_DEFAULT_DEF),
    parameter logic [DATAWIDTH-1:0] PERIOD_MIN     = DATAWIDTH'(PERIOD_MIN_DEF)
) (
    input  logic                 SC_SPEED_TIMER_CLOCK_50,
    input  logic                 SC_SPEED_TIMER_RESET_InHigh,
    input  logic                 SC_SPEED_TIMER_start_InLow,
    input  logic                 SC_SPEED_TIMER_pause_InLow,
    input  logic                 SC_SPEED_TIMER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_SPEED_TIMER_period_InBUS,
    output logic [DATAWIDTH-1:0] SC_SPEED_TIMER_data_OutBUS,
    output logic                 SC_SPEED_TIMER_T0_OutLow,
    output logic                 SC_SPEED_TIMER_running_OutHigh,
    output logic [LEVEL_W-1:0]   SC_SPEED_TIMER_level_OutBUS
);

    localparam logic [DATAWIDTH-1:0] LEVEL_STEP = PERIOD_MIN << 2;

    speedState_e          state;
    speedState_e          stateNext;
    logic [DATAWIDTH-1:0] count;
    logic [DATAWIDTH-1:0] period;
    logic                 t0Low;
    logic                 counting;
    logic                 wrap;
    logic                 levelUp;
    logic [LEVEL_W-1:0]   level;

    function automatic logic [DATAWIDTH-1:0] clampPeriod(input logic [DATAWIDTH-1:0] value);
        return (value < PERIOD_MIN) ? PERIOD_MIN : value;
    endfunction

    // Shorten the period by one level step, never below PERIOD_MIN.
    function automatic logic [DATAWIDTH-1:0] shrinkPeriod(input logic [DATAWIDTH-1:0] value);
        return (value < (PERIOD_MIN + LEVEL_STEP)) ? PERIOD_MIN : (value - LEVEL_STEP);
    endfunction

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (!SC_SPEED_TIMER_start_InLow) stateNext = RUN;
            RUN:     if (!SC_SPEED_TIMER_pause_InLow) stateNext = PAUSE;
            PAUSE:   if (SC_SPEED_TIMER_pause_InLow)  stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    // Count on every edge that leaves the timer in RUN (excluding the start
    // edge itself), so each cycle with pause low costs exactly one cycle.
    assign counting = (state != IDLE) && SC_SPEED_TIMER_pause_InLow;
    // Load takes priority over wrap: a load on the wrap cycle suppresses the tick.
    assign wrap     = counting && SC_SPEED_TIMER_load_InLow && (count == period - 1'b1);

    always_ff @(posedge SC_SPEED_TIMER_CLOCK_50) begin
        if (SC_SPEED_TIMER_RESET_InHigh) begin
            state  <= IDLE;
            count  <= '0;
            period <= PERIOD_DEFAULT;
            t0Low  <= 1'b1;
        end else begin
            state <= stateNext;
            t0Low <= !wrap;
            if (!SC_SPEED_TIMER_load_InLow) begin
                period <= clampPeriod(SC_SPEED_TIMER_period_InBUS);
                count  <= '0;
            end else if (wrap) begin
                count <= '0;
                if (levelUp) begin
                    period <= shrinkPeriod(period);
                end
            end else if (counting) begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef SC_SPEED_TIMER_LEVELUP_EN
    sc_speed_level uLevel (
        .clk     (SC_SPEED_TIMER_CLOCK_50),
        .rst     (SC_SPEED_TIMER_RESET_InHigh),
        .tick    (wrap),
        .load    (!SC_SPEED_TIMER_load_InLow),
        .levelUp (levelUp),
        .level   (level)
    );
`else
    assign levelUp = 1'b0;
    assign level   = '0;
`endif

    assign SC_SPEED_TIMER_data_OutBUS     = count;
    assign SC_SPEED_TIMER_T0_OutLow       = t0Low;
    assign SC_SPEED_TIMER_running_OutHigh = (state == RUN);
    assign SC_SPEED_TIMER_level_OutBUS    = level;

endmodule

// File: tb/tb_sc_speed_timer.sv
// tb_sc_speed_timer -- self-checking bench for sc_speed_timer.
// The reset period is shortened to TB_PERIOD so a full first period fits in a short run.
module tb_sc_speed_timer;

    localparam int          W         = 24;
    localparam int          TB_PERIOD = 37;
    localparam int          PMIN      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          startN;
    logic          pauseN;
    logic          loadN;
    logic [W-1:0]  periodIn;
    logic [W-1:0]  dataOut;
    logic          t0N;
    logic          running;
    logic [3:0]    level;

    int nTests = 0;
    int nFail  = 0;

    // Reference model state (abstract: started/paused flags, integers)
    bit mStarted, mPaused, mT0;
    int mCount, mPeriod, mLevel, mTicks;

    sc_speed_timer #(
        .DATAWIDTH      (W),
        .PERIOD_DEFAULT (24'(TB_PERIOD)),
        .PERIOD_MIN     (24'(PMIN))
    ) dut (
        .SC_SPEED_TIMER_CLOCK_50        (clk),
        .SC_SPEED_TIMER_RESET_InHigh    (rst),
        .SC_SPEED_TIMER_start_InLow     (startN),
        .SC_SPEED_TIMER_pause_InLow     (pauseN),
        .SC_SPEED_TIMER_load_InLow      (loadN),
        .SC_SPEED_TIMER_period_InBUS    (periodIn),
        .SC_SPEED_TIMER_data_OutBUS     (dataOut),
        .SC_SPEED_TIMER_T0_OutLow       (t0N),
        .SC_SPEED_TIMER_running_OutHigh (running),
        .SC_SPEED_TIMER_level_OutBUS    (level)
    );

    always #5 clk = ~clk;

    task automatic modelEdge();
        bit tickNow;
        tickNow = 1'b0;
        if (rst) begin
            mStarted = 0; mPaused = 0; mCount = 0; mPeriod = TB_PERIOD;
            mT0 = 1; mLevel = 0; mTicks = 0;
        end else begin
            if (!loadN) begin
                mPeriod = (int'(periodIn) < PMIN) ? PMIN : int'(periodIn);
                mCount = 0; mLevel = 0; mTicks = 0;
            end else if (mStarted && pauseN) begin
                if (mCount == mPeriod - 1) begin
                    tickNow = 1'b1;
                    mCount  = 0;
                    mTicks++;
`ifdef SC_SPEED_TIMER_LEVELUP_EN
                    if (mTicks % 8 == 0) begin
                        mPeriod = (mPeriod - 4 * PMIN < PMIN) ? PMIN : mPeriod - 4 * PMIN;
                        if (mLevel < 15) mLevel++;
                    end
`endif
                end else begin
                    mCount++;
                end
            end
            mT0 = !tickNow;
            if (mStarted) mPaused = !pauseN;
            else if (!startN) begin mStarted = 1; mPaused = 0; end
        end
    endtask

    // Advance one clock: update the model from current inputs, then settle past the edge.
    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; startN = 1; pauseN = 1; loadN = 1; periodIn = '0;
        step(); step();
        rst = 0;
        nTests++;
        if (dataOut !== '0) begin nFail++; $display("FAIL reset_data got %0d want 0", dataOut); end
        nTests++;
        if (t0N !== 1'b1) begin nFail++; $display("FAIL reset_t0 got %b want 1", t0N); end
        nTests++;
        if (running !== 1'b0) begin nFail++; $display("FAIL reset_running got %b want 0", running); end
        nTests++;
        if (level !== 4'd0) begin nFail++; $display("FAIL reset_level got %0d want 0", level); end
        // Pause is ignored in IDLE
        pauseN = 0; step(); pauseN = 1;
        nTests++;
        if (running !== 1'b0 || dataOut !== '0) begin
            nFail++; $display("FAIL idle_ignores_pause running %b data %0d want 0 0", running, dataOut);
        end
    endtask

    task automatic test_start();
        int n;
        bit seen;
        bit bad;
        startN = 0; step(); startN = 1;
        nTests++;
        if (running !== 1'b1) begin nFail++; $display("FAIL start_running got %b want 1", running); end
        n = 0; seen = 0; bad = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(); n++;
            if (dataOut !== W'(mCount)) bad = 1;
            if (t0N === 1'b0) seen = 1;
        end
        nTests++;
        if (!seen || n != TB_PERIOD) begin
            nFail++; $display("FAIL first_tick got %0d cycles (seen %0d) want %0d", n, seen, TB_PERIOD);
        end
        nTests++;
        if (bad) begin nFail++; $display("FAIL start_count_track data %0d want %0d", dataOut, mCount); end
    endtask

    task automatic test_load5();
        int expCount;
        bit expT0;
        loadN = 0; periodIn = 5; step(); loadN = 1;
        for (int i = 0; i < 20; i++) begin
            expCount = i % 5;
            expT0    = !(expCount == 0 && i > 0);
            nTests++;
            if (dataOut !== W'(expCount) || t0N !== expT0) begin
                nFail++;
                $display("FAIL load5 cyc %0d data %0d t0 %b want %0d %b", i, dataOut, t0N, expCount, expT0);
            end
            step();
        end
    endtask

    task automatic test_clamp();
        loadN = 0; periodIn = 0; step(); loadN = 1;
        for (int i = 0; i < 10; i++) begin
            nTests++;
            if (dataOut !== W'(i % 2) || t0N !== !(i % 2 == 0 && i > 0)) begin
                nFail++;
                $display("FAIL clamp cyc %0d data %0d t0 %b want %0d %b", i, dataOut, t0N, i % 2, !(i % 2 == 0 && i > 0));
            end
            step();
        end
    endtask

    task automatic test_pause();
        int n;
        bit seen;
        loadN = 0; periodIn = 5; step(); loadN = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); if (t0N === 1'b0) seen = 1; end
        nTests++;
        if (!seen) begin nFail++; $display("FAIL pause_sync no tick got 1 want 0"); end
        step(); step();
        n = 2;
        nTests++;
        if (dataOut !== W'(2)) begin nFail++; $display("FAIL pause_pre data %0d want 2", dataOut); end
        pauseN = 0;
        for (int i = 0; i < 3; i++) begin
            step(); n++;
            nTests++;
            if (dataOut !== W'(2) || running !== 1'b0) begin
                nFail++; $display("FAIL pause_hold cyc %0d data %0d running %b want 2 0", i, dataOut, running);
            end
        end
        pauseN = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); n++; if (t0N === 1'b0) seen = 1; end
        nTests++;
        if (!seen || n != 8) begin nFail++; $display("FAIL pause_spacing got %0d want 8", n); end
        nTests++;
        if (running !== 1'b1) begin nFail++; $display("FAIL pause_resume running %b want 1", running); end
    endtask

    task automatic test_load_on_wrap();
        int n;
        bit seen;
        loadN = 0; periodIn = 5; step(); loadN = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin if (dataOut === W'(4)) seen = 1; else step(); end
        loadN = 0; periodIn = 7; step(); loadN = 1;
        nTests++;
        if (!seen || dataOut !== '0 || t0N !== 1'b1) begin
            nFail++; $display("FAIL load_wrap data %0d t0 %b want 0 1", dataOut, t0N);
        end
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); n++; if (t0N === 1'b0) seen = 1; end
        nTests++;
        if (!seen || n != 7) begin nFail++; $display("FAIL load_wrap_spacing got %0d want 7", n); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pauseN   = ($urandom_range(0, 3) != 0);
            loadN    = ($urandom_range(0, 15) != 0);
            periodIn = W'($urandom_range(0, 9));
            step();
            nTests++;
            if (dataOut !== W'(mCount) || t0N !== mT0 || running !== (mStarted && !mPaused) ||
                level !== 4'(mLevel)) begin
                nFail++;
                $display("FAIL random cyc %0d data %0d t0 %b run %b lvl %0d want %0d %b %b %0d",
                         i, dataOut, t0N, running, level, mCount, mT0, mStarted && !mPaused, mLevel);
            end
        end
        pauseN = 1; loadN = 1;
    endtask

`ifdef SC_SPEED_TIMER_LEVELUP_EN
    task automatic test_levelup();
        int n;
        int expSpace;
        int expLevel;
        bit seen;
        loadN = 0; periodIn = 20; step(); loadN = 1;
        for (int k = 1; k <= 136; k++) begin
            expSpace = (k <= 8) ? 20 : (k <= 16) ? 12 : (k <= 24) ? 4 : 2;
            expLevel = (k / 8 > 15) ? 15 : k / 8;
            n = 0; seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin step(); n++; if (t0N === 1'b0) seen = 1; end
            nTests++;
            if (!seen || n != expSpace || level !== 4'(expLevel)) begin
                nFail++;
                $display("FAIL levelup tick %0d spacing %0d level %0d want %0d %0d", k, n, level, expSpace, expLevel);
            end
        end
    endtask
`else
    task automatic test_no_levelup();
        int n;
        bit seen;
        loadN = 0; periodIn = 4; step(); loadN = 1;
        for (int k = 1; k <= 10; k++) begin
            n = 0; seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin step(); n++; if (t0N === 1'b0) seen = 1; end
            nTests++;
            if (!seen || n != 4 || level !== 4'd0) begin
                nFail++; $display("FAIL no_levelup tick %0d spacing %0d level %0d want 4 0", k, n, level);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        loadN = 0; periodIn = 9; step(); loadN = 1;
        step(); step(); step(); step();
        rst = 1; startN = 0; loadN = 0; periodIn = 3;
        step();
        rst = 0; startN = 1; loadN = 1;
        nTests++;
        if (dataOut !== '0 || t0N !== 1'b1 || running !== 1'b0 || level !== 4'd0) begin
            nFail++;
            $display("FAIL reset_mid data %0d t0 %b run %b lvl %0d want 0 1 0 0", dataOut, t0N, running, level);
        end
        step();
        nTests++;
        if (running !== 1'b0 || dataOut !== '0) begin
            nFail++; $display("FAIL reset_mid_idle run %b data %0d want 0 0", running, dataOut);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_start();
        test_load5();
        test_clamp();
        test_pause();
        test_load_on_wrap();
        test_random();
`ifdef SC_SPEED_TIMER_LEVELUP_EN
        test_levelup();
`else
        test_no_levelup();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
